// File: rtl/axi_sram_sub.sv
// axi_sram_sub: AXI subordinate serving one read or write burst at a time from a
// single-port synchronous SRAM with 1-cycle read latency. All bursts are INCR.
// Ports:
//   i_aclk, i_arst            clock, asynchronous active-high reset
//   axi_aw*/axi_w*/axi_b*     write address / data / response channels
//   axi_ar*/axi_r*            read address / data channels
//   o_sram_en/we/addr/wdata/wstrb, i_sram_rdata   SRAM port (rdata valid 1 cycle after a read strobe)
module axi_sram_sub #(
  parameter int               AWIDTH    = 32,
  parameter int               DWIDTH    = 32,
  parameter int               IDWIDTH   = 4,
  parameter int               LENWIDTH  = 8,
  parameter int               DEPTH     = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0,
  localparam int              AIDX      = $clog2(DEPTH)
) (
  input  logic                i_aclk,
  input  logic                i_arst,
  // write address
  input  logic                axi_awvalid_i,
  output logic                axi_awready_o,
  input  logic [IDWIDTH-1:0]  axi_awid_i,
  input  logic [AWIDTH-1:0]   axi_awaddr_i,
  input  logic [LENWIDTH-1:0] axi_awlen_i,
  input  logic [2:0]          axi_awsize_i,
  // write data
  input  logic                axi_wvalid_i,
  output logic                axi_wready_o,
  input  logic [DWIDTH-1:0]   axi_wdata_i,
  input  logic [DWIDTH/8-1:0] axi_wstrb_i,
  input  logic                axi_wlast_i,
  // write response
  output logic                axi_bvalid_o,
  input  logic                axi_bready_i,
  output logic [IDWIDTH-1:0]  axi_bid_o,
  output logic [1:0]          axi_bresp_o,
  // read address
  input  logic                axi_arvalid_i,
  output logic                axi_arready_o,
  input  logic [IDWIDTH-1:0]  axi_arid_i,
  input  logic [AWIDTH-1:0]   axi_araddr_i,
  input  logic [LENWIDTH-1:0] axi_arlen_i,
  input  logic [2:0]          axi_arsize_i,
  // read data
  output logic                axi_rvalid_o,
  input  logic                axi_rready_i,
  output logic [IDWIDTH-1:0]  axi_rid_o,
  output logic [DWIDTH-1:0]   axi_rdata_o,
  output logic [1:0]          axi_rresp_o,
  output logic                axi_rlast_o,
  // SRAM
  output logic                o_sram_en,
  output logic                o_sram_we,
  output logic [AIDX-1:0]     o_sram_addr,
  output logic [DWIDTH-1:0]   o_sram_wdata,
  output logic [DWIDTH/8-1:0] o_sram_wstrb,
  input  logic [DWIDTH-1:0]   i_sram_rdata
);

  localparam int              BSHIFT = $clog2(DWIDTH / 8);
  localparam logic [AWIDTH:0] SPAN   = (AWIDTH + 1)'(DEPTH) << BSHIFT;
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;
  localparam logic [1:0]      DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e                state_q;
  logic                  last_rd_q;    // last served request was a read
  logic [IDWIDTH-1:0]    id_q;
  logic [AWIDTH-1:0]     addr_q;
  logic [LENWIDTH-1:0]   len_q;
  logic                  size_ok_q;
  logic [LENWIDTH:0]     beat_q;       // one spare bit so len = max can count past the end
  logic                  err_dec_q, err_slv_q;
  logic                  bvalid_q;
  logic [IDWIDTH-1:0]    bid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q, rlast_q;
  logic [IDWIDTH-1:0]    rid_q;
  logic [DWIDTH-1:0]     rdata_q;
  logic [1:0]            rresp_q;
  logic                  infl_q, infl_ok_q, infl_last_q;
  logic [1:0]            infl_resp_q;

  // Arbitration: on a tie, serve the opposite of the last served type.
  logic pick_read, pick_write, in_idle;
  assign pick_read  = axi_arvalid_i && (!axi_awvalid_i || !last_rd_q);
  assign pick_write = axi_awvalid_i && !pick_read;
  assign in_idle    = (state_q == IDLE) && !i_arst;
  assign axi_arready_o = in_idle && pick_read;
  assign axi_awready_o = in_idle && pick_write;

  // Per-beat address; the extra MSB catches wrap past 2^AWIDTH, which is always out of range.
  logic [AWIDTH:0]   beat_addr;
  logic [AWIDTH-1:0] beat_off;
  logic              in_range, beat_ok, is_last;
  logic [1:0]        beat_resp;
  assign beat_addr = {1'b0, addr_q} + ((AWIDTH + 1)'(beat_q) << BSHIFT);
  assign beat_off  = beat_addr[AWIDTH-1:0] - BASE_ADDR;
  assign in_range  = !beat_addr[AWIDTH] && (beat_addr[AWIDTH-1:0] >= BASE_ADDR)
                     && ({1'b0, beat_off} < SPAN);
  assign beat_ok   = in_range && size_ok_q;
  assign beat_resp = !in_range ? DECERR : (!size_ok_q ? SLVERR : OKAY);
  assign is_last   = (beat_q == {1'b0, len_q});

  logic w_hs, rd_issue, dec_nxt, slv_nxt;
  assign w_hs     = (state_q == WDATA) && axi_wvalid_i;
  // At most one beat in flight or held; issue only when the R register will be free.
  assign rd_issue = (state_q == RDATA) && !infl_q && (!rvalid_q || axi_rready_i)
                    && (beat_q <= {1'b0, len_q});
  assign dec_nxt  = err_dec_q || !in_range;
  assign slv_nxt  = err_slv_q || (axi_wlast_i != is_last);

  assign axi_wready_o = (state_q == WDATA);
  assign o_sram_en    = (w_hs || rd_issue) && beat_ok;
  assign o_sram_we    = (state_q == WDATA);
  assign o_sram_addr  = beat_off[BSHIFT +: AIDX];
  assign o_sram_wdata = axi_wdata_i;
  assign o_sram_wstrb = axi_wstrb_i;

  assign axi_bvalid_o = bvalid_q;
  assign axi_bid_o    = bid_q;
  assign axi_bresp_o  = bresp_q;
  assign axi_rvalid_o = rvalid_q;
  assign axi_rid_o    = rid_q;
  assign axi_rdata_o  = rdata_q;
  assign axi_rresp_o  = rresp_q;
  assign axi_rlast_o  = rlast_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge i_aclk or posedge i_arst) begin
    if (i_arst) begin
      state_q     <= IDLE;
      last_rd_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_ok_q   <= 1'b0;
      beat_q      <= '0;
      err_dec_q   <= 1'b0;
      err_slv_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= OKAY;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= OKAY;
      infl_q      <= 1'b0;
      infl_ok_q   <= 1'b0;
      infl_last_q <= 1'b0;
      infl_resp_q <= OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_read) begin
            id_q      <= axi_arid_i;
            addr_q    <= axi_araddr_i;
            len_q     <= axi_arlen_i;
            size_ok_q <= (axi_arsize_i == 3'(BSHIFT));
            beat_q    <= '0;
            last_rd_q <= 1'b1;
            state_q   <= RDATA;
          end else if (pick_write) begin
            id_q      <= axi_awid_i;
            addr_q    <= axi_awaddr_i;
            len_q     <= axi_awlen_i;
            size_ok_q <= (axi_awsize_i == 3'(BSHIFT));
            beat_q    <= '0;
            err_dec_q <= 1'b0;
            err_slv_q <= (axi_awsize_i != 3'(BSHIFT));
            last_rd_q <= 1'b0;
            state_q   <= WDATA;
          end
        end
        WDATA: begin
          if (axi_wvalid_i) begin
            err_dec_q <= dec_nxt;
            err_slv_q <= slv_nxt;
            beat_q    <= beat_q + (LENWIDTH + 1)'(1);
            if (is_last) begin
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= dec_nxt ? DECERR : (slv_nxt ? SLVERR : OKAY);
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (axi_bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RDATA: begin
          if (rvalid_q && axi_rready_i) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) state_q <= IDLE;
          end
          // SRAM data for the beat issued last cycle is on i_sram_rdata now.
          if (infl_q) begin
            infl_q   <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= infl_ok_q ? i_sram_rdata : '0;
            rresp_q  <= infl_resp_q;
            rlast_q  <= infl_last_q;
            rid_q    <= id_q;
          end
          if (rd_issue) begin
            infl_q      <= 1'b1;
            infl_ok_q   <= beat_ok;
            infl_resp_q <= beat_resp;
            infl_last_q <= is_last;
            beat_q      <= beat_q + (LENWIDTH + 1)'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_sub.sv
// Self-checking bench for axi_sram_sub: directed sequence with random data and random
// rready, checked against a byte-address/array reference model of the subordinate.
module tb_axi_sram_sub;
  localparam int          AW = 32, DW = 32, IDW = 4, LW = 8, DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk = 1'b0, rst = 1'b0;
  logic awvalid = 0, awready; logic [IDW-1:0] awid = 0; logic [AW-1:0] awaddr = 0;
  logic [LW-1:0] awlen = 0; logic [2:0] awsize = 0;
  logic wvalid = 0, wready, wlast = 0; logic [DW-1:0] wdata = 0; logic [3:0] wstrb = 0;
  logic bvalid, bready = 0; logic [IDW-1:0] bid; logic [1:0] bresp;
  logic arvalid = 0, arready; logic [IDW-1:0] arid = 0; logic [AW-1:0] araddr = 0;
  logic [LW-1:0] arlen = 0; logic [2:0] arsize = 0;
  logic rvalid, rready = 0, rlast; logic [IDW-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
  logic sram_en, sram_we; logic [3:0] sram_addr; logic [DW-1:0] sram_wdata, sram_rdata;
  logic [3:0] sram_wstrb;

  always #5 clk = ~clk;

  axi_sram_sub #(.AWIDTH(AW), .DWIDTH(DW), .IDWIDTH(IDW), .LENWIDTH(LW), .DEPTH(DEPTH),
                 .BASE_ADDR(BASE)) dut (
    .i_aclk(clk), .i_arst(rst),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready), .axi_awid_i(awid), .axi_awaddr_i(awaddr),
    .axi_awlen_i(awlen), .axi_awsize_i(awsize),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
    .axi_wlast_i(wlast),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bid_o(bid), .axi_bresp_o(bresp),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_arid_i(arid), .axi_araddr_i(araddr),
    .axi_arlen_i(arlen), .axi_arsize_i(arsize),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rid_o(rid), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .o_sram_wstrb(sram_wstrb), .i_sram_rdata(sram_rdata));

  // SRAM model plus an access log.
  typedef struct { int idx; logic [31:0] data; logic [3:0] strb; } wr_t;
  logic [31:0] sram [DEPTH];
  wr_t         wr_log[$];
  int          rd_strobes = 0;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wstrb[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        wr_log.push_back('{int'(sram_addr), sram_wdata, sram_wstrb});
      end else begin
        sram_rdata <= sram[sram_addr];
        rd_strobes <= rd_strobes + 1;
      end
    end
  end

  // Reference state: expected memory contents and arbitration history.
  logic [31:0] exp_mem [DEPTH];
  bit          last_read = 0;
  bit          tb_busy = 0;
  int          ready_viol = 0;
  int          n_pass = 0, n_fail = 0, n_total = 0;

  // While a transaction is in service no address channel may be ready.
  always @(negedge clk) begin
    if (tb_busy && (awready || arready)) ready_viol++;
    if (awready && arready) ready_viol++;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat outcome from the address rules: wrapped or outside the window -> DECERR,
  // narrow -> SLVERR, else OKAY with its word index.
  function automatic void ref_beat(input logic [31:0] addr, input int beat, input logic [2:0] size,
                                   output logic [1:0] resp, output int idx);
    longint ba = longint'(addr) + longint'(beat) * 4;
    longint lo = longint'(BASE);
    idx = -1;
    if (ba >= 64'h1_0000_0000 || ba < lo || ba >= lo + DEPTH * 4) resp = DECERR;
    else if (size != 3'd2) resp = SLVERR;
    else begin resp = OKAY; idx = int'((ba - lo) / 4); end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_read = 0;
    tb_busy   = 0;
  endtask

  // Write burst; early >= 0 puts wlast on that beat instead of the last one.
  task automatic do_write(string tag, logic [3:0] id, logic [31:0] addr, int len,
                          logic [2:0] size, int early);
    wr_t exp_w[$];
    bit any_dec = 0, any_slv = 0;
    logic [1:0] r, exp_b;
    int idx, cyc;
    logic [31:0] d;
    bit is_last_b;
    wr_log.delete();
    awvalid = 1; awid = id; awaddr = addr; awlen = 8'(len); awsize = size;
    cyc = 0;
    forever begin #1; if (awready || cyc >= 50) break; @(posedge clk); cyc++; end
    chk({tag, ".aw_handshake"}, 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 0; tb_busy = 1;
    for (int b = 0; b <= len; b++) begin
      d = $urandom;
      is_last_b = (b == len);
      wvalid = 1; wdata = d; wstrb = 4'hF;
      wlast = (early >= 0) ? (b == early) : is_last_b;
      cyc = 0;
      while (!wready && cyc < 50) begin @(posedge clk); #1; cyc++; end
      chk({tag, ".w_handshake"}, 64'(wready), 64'd1);
      ref_beat(addr, b, size, r, idx);
      if (r == DECERR) any_dec = 1;
      if (size != 3'd2 || wlast != is_last_b) any_slv = 1;
      if (r == OKAY) begin exp_w.push_back('{idx, d, 4'hF}); exp_mem[idx] = d; end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0; bready = 1;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    exp_b = any_dec ? DECERR : (any_slv ? SLVERR : OKAY);
    chk({tag, ".bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, ".bresp"}, 64'(bresp), 64'(exp_b));
    chk({tag, ".bid"}, 64'(bid), 64'(id));
    @(posedge clk); #1;
    bready = 0; tb_busy = 0; last_read = 0;
    chk({tag, ".n_writes"}, 64'(wr_log.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      chk({tag, ".wr_addr"}, 64'(wr_log[i].idx), 64'(exp_w[i].idx));
      chk({tag, ".wr_data"}, 64'(wr_log[i].data), 64'(exp_w[i].data));
      chk({tag, ".wr_strb"}, 64'(wr_log[i].strb), 64'(exp_w[i].strb));
    end
  endtask

  // Read burst; rand_rdy toggles rready randomly, chk_lat checks the first-beat latency.
  task automatic do_read(string tag, logic [3:0] id, logic [31:0] addr, int len,
                         logic [2:0] size, bit rand_rdy, bit chk_lat);
    int got = 0, cyc = 0, lat = 0, idx, n_ok = 0;
    bit first = 1, stalled = 0;
    logic [31:0] p_data; logic [1:0] p_resp, r; logic p_last;
    logic [31:0] exp_d;
    arvalid = 1; arid = id; araddr = addr; arlen = 8'(len); arsize = size;
    forever begin #1; if (arready || cyc >= 50) break; @(posedge clk); cyc++; end
    chk({tag, ".ar_handshake"}, 64'(arready), 64'd1);
    @(posedge clk);
    rd_strobes = 0;
    #1;
    arvalid = 0; tb_busy = 1; cyc = 0;
    while (got <= len && cyc < 200) begin
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        chk({tag, ".stall_rvalid"}, 64'(rvalid), 64'd1);
        chk({tag, ".stall_rdata"}, 64'(rdata), 64'(p_data));
        chk({tag, ".stall_rresp"}, 64'(rresp), 64'(p_resp));
        chk({tag, ".stall_rlast"}, 64'(rlast), 64'(p_last));
      end
      stalled = 0;
      if (rvalid) begin
        if (first && chk_lat) chk({tag, ".first_latency"}, 64'(lat), 64'd2);
        first = 0;
        if (rready) begin
          ref_beat(addr, got, size, r, idx);
          exp_d = (r == OKAY) ? exp_mem[idx] : 32'h0;
          if (r == OKAY) n_ok++;
          chk({tag, ".rdata"}, 64'(rdata), 64'(exp_d));
          chk({tag, ".rresp"}, 64'(rresp), 64'(r));
          chk({tag, ".rlast"}, 64'(rlast), 64'(got == len));
          chk({tag, ".rid"}, 64'(rid), 64'(id));
          got++;
        end else begin
          stalled = 1; p_data = rdata; p_resp = rresp; p_last = rlast;
        end
      end
      @(posedge clk); #1;
      lat++; cyc++;
    end
    chk({tag, ".beats"}, 64'(got), 64'(len + 1));
    chk({tag, ".rd_strobes"}, 64'(rd_strobes), 64'(n_ok));
    rready = 0; tb_busy = 0; last_read = 1;
  endtask

  initial begin
    bit exp_rd;
    // Reset values, observed while reset is held.
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.awready", 64'(awready), 64'd0);
    chk("rst.arready", 64'(arready), 64'd0);
    chk("rst.wready", 64'(wready), 64'd0);
    chk("rst.bvalid", 64'(bvalid), 64'd0);
    chk("rst.rvalid", 64'(rvalid), 64'd0);
    chk("rst.rlast", 64'(rlast), 64'd0);
    chk("rst.bresp", 64'(bresp), 64'(OKAY));
    chk("rst.rresp", 64'(rresp), 64'(OKAY));
    chk("rst.bid", 64'(bid), 64'd0);
    chk("rst.rid", 64'(rid), 64'd0);
    chk("rst.rdata", 64'(rdata), 64'd0);
    chk("rst.sram_en", 64'(sram_en), 64'd0);
    do_reset();

    // Basic write then read-back of four words at the base.
    do_write("t1", 4'd5, BASE, 3, 3'd2, -1);
    do_read("t2", 4'd9, BASE, 3, 3'd2, 0, 1);

    // Bursts straddling the top of the window.
    do_write("t3w", 4'd3, BASE + (DEPTH - 1) * 4, 1, 3'd2, -1);
    do_read("t3r", 4'd4, BASE + (DEPTH - 1) * 4, 1, 3'd2, 0, 0);

    // Simultaneous requests alternate, starting with read after reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      awvalid = 1; awid = 4'd6; awaddr = BASE + 32'(4 * (k + 4)); awlen = 0; awsize = 3'd2;
      arvalid = 1; arid = 4'd7; araddr = BASE; arlen = 0; arsize = 3'd2;
      #1;
      exp_rd = !last_read;
      chk("t4.arready", 64'(arready), 64'(exp_rd));
      chk("t4.awready", 64'(awready), 64'(!exp_rd));
      chk("t4.order", 64'(exp_rd), 64'(k % 2 == 0));
      if (exp_rd) do_read("t4r", 4'd7, BASE, 0, 3'd2, 0, 0);
      else        do_write("t4w", 4'd6, BASE + 32'(4 * (k + 4)), 0, 3'd2, -1);
    end
    awvalid = 0; arvalid = 0;

    // Eight-beat read with random back-pressure.
    do_write("t5w", 4'd1, BASE, 7, 3'd2, -1);
    do_read("t5r", 4'd2, BASE, 7, 3'd2, 1, 0);

    // Error cases: narrow size, early wlast, narrow read, wrapped address.
    do_write("t6n", 4'd8, BASE + 32'd32, 1, 3'd0, -1);
    do_write("t6e", 4'd10, BASE + 32'd40, 3, 3'd2, 1);
    do_read("t6r", 4'd11, BASE, 1, 3'd0, 0, 0);
    do_read("t6wrap", 4'd12, 32'hFFFF_FFFC, 1, 3'd2, 0, 0);

    // Reset in the middle of a stalled read burst.
    arvalid = 1; arid = 4'd2; araddr = BASE; arlen = 8'd7; arsize = 3'd2; rready = 0;
    #1 chk("t7.arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1; awid = 4'd1; awaddr = BASE; awlen = 0; awsize = 3'd2;
    repeat (4) @(posedge clk);
    #1;
    chk("t7.rvalid_held", 64'(rvalid), 64'd1);
    chk("t7.awready_busy", 64'(awready), 64'd0);
    rst = 1'b1;
    #1;
    chk("t7.awready", 64'(awready), 64'd0);
    chk("t7.arready", 64'(arready), 64'd0);
    chk("t7.wready", 64'(wready), 64'd0);
    chk("t7.bvalid", 64'(bvalid), 64'd0);
    chk("t7.rvalid", 64'(rvalid), 64'd0);
    chk("t7.rlast", 64'(rlast), 64'd0);
    chk("t7.sram_en", 64'(sram_en), 64'd0);
    awvalid = 0; arvalid = 0;
    @(posedge clk); #1;
    rst = 1'b0; last_read = 0;
    do_read("t7rec", 4'd3, BASE, 3, 3'd2, 0, 1);

    chk("ready_exclusive", 64'(ready_viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
